// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, next-PC select encodings
// (also decoded by the controller) and the fetch-stage state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_INST_W = 16;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [1:0] PC_LR  = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    ERR   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC mux: increment, signed relative branch, register jump or link return.
// Purely combinational; all adds wrap modulo 2^ADDR_W.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int OFF_W  = 12
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [ADDR_W-1:0] i_rs_data,
  input  logic [ADDR_W-1:0] i_lr,
  input  logic [1:0]        i_pc_sel,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic [ADDR_W-1:0] w_off_sx;

  assign w_off_sx = {{(ADDR_W-OFF_W){i_off[OFF_W-1]}}, i_off};

  always_comb begin
    o_next_pc = i_pc + ADDR_W'(1);
    case (i_pc_sel)
      PC_BR:   o_next_pc = i_pc + w_off_sx;
      PC_REG:  o_next_pc = i_rs_data;
      PC_LR:   o_next_pc = i_lr;
      default: o_next_pc = i_pc + ADDR_W'(1);
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: req/ack instruction fetch, one-cycle EXEC presentation, then PC/LR update.
// Best case 2 cycles per instruction; memory stalls extend FETCH until ack or timeout (sticky ERR).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                INST_W   = CPU_INST_W,
  parameter int                OFF_W    = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] lr,
  input  logic [1:0]        pc_sel,
  input  logic              lr_en,
  input  logic [ADDR_W-1:0] rs_data,
  output logic              fetch_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_lr;
  logic [INST_W-1:0] r_inst;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + ADDR_W'(1);

  next_pc_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_next_pc_calc (
    .i_pc      (r_pc),
    .i_off     (r_inst[OFF_W-1:0]),
    .i_rs_data (rs_data),
    .i_lr      (r_lr),
    .i_pc_sel  (pc_sel),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_lr    <= '0;
      r_inst  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_cnt   <= '0;
            r_state <= EXEC;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        EXEC: begin
          r_pc    <= w_next_pc;
          if (lr_en) begin
            r_lr <= w_pc_inc;
          end
          r_state <= FETCH;
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state <= ERR;
        end
      endcase
    end
  end

  assign imem_req   = (r_state == FETCH);
  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_valid = (r_state == EXEC);
  assign pc         = r_pc;
  assign lr         = r_lr;
  assign fetch_err  = (r_state == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table of instructions (stall, data, next-PC controls,
// expected addresses/LR) plus hand sequences for timeout, error hold and reset corner cases.
module tb_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] pc;
  logic [15:0] lr;
  logic [1:0]  pc_sel;
  logic        lr_en;
  logic [15:0] rs_data;
  logic        fetch_err;

  int n_chk;
  int n_fail;

  fetch_unit #(
    .ADDR_W   (16),
    .INST_W   (16),
    .OFF_W    (12),
    .RESET_PC (16'h0000),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .lr         (lr),
    .pc_sel     (pc_sel),
    .lr_en      (lr_en),
    .rs_data    (rs_data),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          wt;
    logic [15:0] rdata;
    logic [1:0]  sel;
    logic        len;
    logic [15:0] rs;
    logic [15:0] addr;
    logic [15:0] nxt;
    logic [15:0] lr_exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge after EXEC.
  task automatic run_vec(input vec_t v);
    for (int w = 0; w < v.wt; w++) begin
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      pc_sel     = 2'b10;
      lr_en      = 1'b1;
      rs_data    = 16'hBEEF;
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", {16'd0, imem_addr}, {16'd0, v.addr});
      chk("stall_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", {16'd0, imem_addr}, {16'd0, v.addr});
    chk("fetch_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 16'hFFFF;
    pc_sel     = v.sel;
    lr_en      = v.len;
    rs_data    = v.rs;
    chk("exec_valid", {31'd0, inst_valid}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_inst", {16'd0, inst}, {16'd0, v.rdata});
    chk("exec_pc", {16'd0, pc}, {16'd0, v.addr});
    chk("exec_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("next_pc", {16'd0, pc}, {16'd0, v.nxt});
    chk("next_addr", {16'd0, imem_addr}, {16'd0, v.nxt});
    chk("next_lr", {16'd0, lr}, {16'd0, v.lr_exp});
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("inst_hold", {16'd0, inst}, {16'd0, v.rdata});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, {16'd0, imem_addr}, 32'd0);
    chk({tag, "_pc"}, {16'd0, pc}, 32'd0);
    chk({tag, "_lr"}, {16'd0, lr}, 32'd0);
    chk({tag, "_inst"}, {16'd0, inst}, 32'd0);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    n_chk  = 0;
    n_fail = 0;

    //            wt  rdata     sel    len   rs        addr      nxt       lr
    vecs[0]  = '{0, 16'h1000, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
    vecs[1]  = '{0, 16'h1000, 2'b00, 1'b0, 16'h0000, 16'h0001, 16'h0002, 16'h0000};
    vecs[2]  = '{0, 16'h1000, 2'b00, 1'b0, 16'h0000, 16'h0002, 16'h0003, 16'h0000};
    vecs[3]  = '{1, 16'h2000, 2'b10, 1'b0, 16'h0010, 16'h0003, 16'h0010, 16'h0000};
    vecs[4]  = '{0, 16'hAFFC, 2'b01, 1'b0, 16'h0000, 16'h0010, 16'h000C, 16'h0000};
    vecs[5]  = '{3, 16'h3000, 2'b10, 1'b0, 16'hFFFF, 16'h000C, 16'hFFFF, 16'h0000};
    vecs[6]  = '{0, 16'h1234, 2'b00, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[7]  = '{0, 16'h3000, 2'b10, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[8]  = '{0, 16'h5002, 2'b01, 1'b0, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[9]  = '{0, 16'h3000, 2'b10, 1'b0, 16'h0020, 16'h0001, 16'h0020, 16'h0000};
    vecs[10] = '{0, 16'h4000, 2'b10, 1'b1, 16'h0400, 16'h0020, 16'h0400, 16'h0021};
    vecs[11] = '{2, 16'h6000, 2'b11, 1'b1, 16'h0000, 16'h0400, 16'h0021, 16'h0401};
    vecs[12] = '{0, 16'h07FF, 2'b01, 1'b0, 16'h0000, 16'h0021, 16'h0820, 16'h0401};
    vecs[13] = '{0, 16'h6000, 2'b11, 1'b0, 16'h0000, 16'h0820, 16'h0401, 16'h0401};

    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    pc_sel     = 2'b00;
    lr_en      = 1'b0;
    rs_data    = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i]);
    end

    // Ack lands exactly on the last allowed FETCH cycle: no error.
    hv = '{TIMEOUT - 1, 16'h1111, 2'b00, 1'b0, 16'h0000, 16'h0401, 16'h0402, 16'h0401};
    run_vec(hv);

    // Ack withheld for TIMEOUT cycles: sticky error, request dropped, PC/LR frozen.
    imem_ack = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
    end
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    chk("to_valid", {31'd0, inst_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 16'h7777;
    pc_sel     = 2'b10;
    lr_en      = 1'b1;
    rs_data    = 16'h5555;
    repeat (5) @(negedge clk);
    chk("err_hold", {31'd0, fetch_err}, 32'd1);
    chk("err_req", {31'd0, imem_req}, 32'd0);
    chk("err_pc", {16'd0, pc}, 32'h0402);
    chk("err_lr", {16'd0, lr}, 32'h0401);
    chk("err_inst", {16'd0, inst}, 32'h1111);

    rst      = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("err_rst");

    // Move PC/LR off their reset values, then reset during a stalled fetch whose ack meets rst.
    hv = '{0, 16'h3000, 2'b10, 1'b1, 16'h0300, 16'h0000, 16'h0300, 16'h0001};
    run_vec(hv);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 16'h9999;
    rst        = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    chk_reset_state("mid_rst");
    @(negedge clk);
    chk("mid_rst_refetch", {31'd0, imem_req}, 32'd1);
    chk("mid_rst_noexec", {31'd0, inst_valid}, 32'd0);
    hv = '{0, 16'h2222, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
    run_vec(hv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the controller in the single-cycle 16-bit CPU.
- Holds the PC and the link register (LR), and fetches from instruction memory with a req/ack handshake.
- Presents `inst` to the controller for exactly one execute cycle, then computes the next PC from the controller's `pc_sel` and `lr_en`.
- Detects memory that never acknowledges, using a fetch timeout.

Parameters:
- ADDR_W, 16, PC/LR/instruction-address width.
- INST_W, 16, instruction width; opcode is inst[INST_W-1:INST_W-4].
- OFF_W, 12, width of the signed branch offset taken from inst[OFF_W-1:0].
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 16, maximum FETCH cycles without ack before error (≥2).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, high throughout FETCH
- imem_addr  out  ADDR_W  fetch address (= PC), stable while imem_req high
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  INST_W  instruction word
- inst  out  INST_W  registered instruction to controller
- inst_valid  out  1  high only in EXEC
- pc  out  ADDR_W  current PC
- lr  out  ADDR_W  current link register
- pc_sel  in  2  next-PC select from controller, sampled in EXEC only
- lr_en  in  1  link write enable from controller, sampled in EXEC only
- rs_data  in  ADDR_W  register-file jump target
- fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, lr=0, inst=0, inst_valid=0, fetch_err=0, timeout counter=0.
  - imem_req is Moore-decoded from state, so it is high in the first cycle after reset.
- FSM states: FETCH, EXEC, ERR.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack=1: inst<=imem_rdata, counter<=0, go to EXEC.
  - Otherwise counter increments; if counter==TIMEOUT-1 and no ack, go to ERR.
- EXEC:
  - inst_valid=1 and imem_req=0. Lasts exactly one cycle, then go to FETCH.
  - At the end of the cycle, pc is updated per pc_sel:
    - 00 → pc+1
    - 01 → pc + sign-extended inst[OFF_W-1:0]
    - 10 → rs_data
    - 11 → lr
  - If lr_en=1: lr<=pc+1 (the pc of the executing instruction, plus 1).
- ERR:
  - imem_req=0, inst_valid=0, fetch_err=1. pc and lr are frozen.
  - Only rst exits ERR.
- Throughput: best case is 2 cycles per instruction (ack in the first FETCH cycle). Each extra wait cycle adds 1.
- Arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W; pc+1 at 0xFFFF wraps to 0x0000.
  - Branch offset is two's complement, OFF_W bits; the add wraps silently.
- Simultaneous events:
  - Ack on the timeout cycle: ack wins, go to EXEC, no error.
  - pc_sel=11 with lr_en=1: pc<=old lr and lr<=pc+1 in the same edge (swap).
- Outside EXEC, pc_sel, lr_en and rs_data are ignored; pc and lr hold.
- imem_rdata is ignored when imem_ack=0 and outside FETCH.
- Reset mid-operation:
  - rst high in any state forces the reset values at that edge; an in-flight fetch is abandoned.
  - An ack arriving in the reset cycle is discarded.
- inst holds its value through FETCH; it is only meaningful when inst_valid=1.

Decomposition:
- Shared package cpu_pkg holds:
  - the PC_SEL encodings (PC_INC=2'b00, PC_BR=2'b01, PC_REG=2'b10, PC_LR=2'b11), also used by the controller;
  - the fetch state enum (FETCH, EXEC, ERR);
  - the ADDR_W and INST_W defaults.
- One sub-module, next_pc_calc: purely combinational, computing the next PC from pc, inst offset, rs_data, lr and pc_sel. It is verified standalone.

Test Plan:
- Reset, RESET_PC=0, ack every FETCH first cycle, rdata=0x1000, pc_sel=00 → imem_addr sequence 0,1,2; inst_valid pulses every 2nd cycle; inst=0x1000.
- Branch at pc=0x0010, inst[11:0]=0xFFC, pc_sel=01 → next imem_addr=0x000C.
- Branch at pc=0xFFFF, inst[11:0]=0x002, pc_sel=01 → next imem_addr=0x0001 (wrap).
- At pc=0x0020: rs_data=0x0400, pc_sel=10, lr_en=1 → pc=0x0400, lr=0x0021.
  - Then pc_sel=11, lr_en=1 at pc=0x0400 → pc=0x0021, lr=0x0401.
- Ack withheld for TIMEOUT cycles → fetch_err=1, imem_req=0 from the next cycle and held.
  - Ack exactly on cycle TIMEOUT-1 → EXEC, no error.
  - rst then clears fetch_err and restarts at RESET_PC.
- rst asserted during a 3-cycle-latency fetch with ack coinciding with rst → inst stays 0, pc=RESET_PC, a new fetch starts the next cycle.
